// File: rtl/ed25519_bpm_io_sequencer.sv
// ed25519_bpm_io_sequencer: word-serial K fetch, optional clamp, core start and Q write-back
//   ICLK, IRST          : clock, synchronous active-high reset
//   IEN, OREADY, ODONE  : start request (IDLE only), idle flag, completion pulse
//   OKADDR, OKRDEN, IK  : K RAM read port, data sampled READ_LAT edges after the address
//   OQADDR, OQWREN, OQ  : result write port, OQADDR MSB selects Qx
//   OCORE_*, ICORE_*    : base-point multiplier core start/done handshake and operands
module ed25519_bpm_io_sequencer #(
   parameter int WORD_W   = 32,
   parameter int ADDR_W   = $clog2(256 / WORD_W),
   parameter int READ_LAT = 1,
   parameter int CLAMP    = 1,
   parameter int OUT_X    = 0
) (
   input  logic              ICLK,
   input  logic              IRST,
   input  logic              IEN,
   output logic              OREADY,
   output logic              ODONE,
   output logic [ADDR_W-1:0] OKADDR,
   output logic              OKRDEN,
   input  logic [WORD_W-1:0] IK,
   output logic [ADDR_W:0]   OQADDR,
   output logic              OQWREN,
   output logic [WORD_W-1:0] OQ,
   output logic              OCORE_START,
   output logic [255:0]      OCORE_K,
   input  logic              ICORE_DONE,
   input  logic [255:0]      ICORE_QY,
   input  logic [255:0]      ICORE_QX
);
   localparam int NW = 256 / WORD_W;
   localparam logic [ADDR_W:0] LAST_K = (ADDR_W + 1)'(NW - 1);
   localparam logic [ADDR_W:0] LAST_Q = (ADDR_W + 1)'(OUT_X != 0 ? 2 * NW - 1 : NW - 1);
   localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DRAIN = 3'd2, START = 3'd3,
                          WAIT = 3'd4, STORE = 3'd5, DONE = 3'd6;
   logic [2:0]        state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              pv_q;
   logic [ADDR_W-1:0] pa_q;
   logic [255:0]      k_q, k_d, k_ins, qy_q, qy_d, qx_q, qx_d, q_sel;
   logic              cap_v;
   logic [ADDR_W-1:0] cap_a;
   // With one cycle of latency the word arrives while its address is still driven;
   // with two, a one-stage copy of the read request tags the returning word.
   assign cap_v = READ_LAT == 1 ? state_q == FETCH : pv_q;
   assign cap_a = READ_LAT == 1 ? cnt_q[ADDR_W-1:0] : pa_q;
   always_comb begin
      k_ins = k_q;
      k_ins[cap_a * WORD_W +: WORD_W] = IK;
   end
   // Clamping is folded into every capture so OCORE_K is final when START fires.
   assign k_d = !cap_v ? k_q : CLAMP != 0 ? {2'b01, k_ins[253:3], 3'b000} : k_ins;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      qy_d    = qy_q;
      qx_d    = qx_q;
      case (state_q)
         IDLE:  state_d = IEN ? FETCH : IDLE;
         FETCH: begin
            cnt_d = cnt_q == LAST_K ? '0 : cnt_q + 1'b1;
            if (cnt_q == LAST_K) state_d = READ_LAT == 1 ? START : DRAIN;
         end
         DRAIN: state_d = cap_v ? START : DRAIN;
         START: state_d = WAIT;
         WAIT:  if (ICORE_DONE) begin
            state_d = STORE;
            qy_d    = ICORE_QY;
            qx_d    = ICORE_QX;
         end
         STORE: begin
            cnt_d   = cnt_q == LAST_Q ? '0 : cnt_q + 1'b1;
            state_d = cnt_q == LAST_Q ? DONE : STORE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge ICLK) begin
      if (IRST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pv_q    <= 1'b0;
         pa_q    <= '0;
         k_q     <= '0;
         qy_q    <= '0;
         qx_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pv_q    <= state_q == FETCH;
         pa_q    <= cnt_q[ADDR_W-1:0];
         k_q     <= k_d;
         qy_q    <= qy_d;
         qx_q    <= qx_d;
      end
   end
   assign q_sel       = cnt_q[ADDR_W] ? qx_q : qy_q;
   assign OREADY      = state_q == IDLE;
   assign ODONE       = state_q == DONE;
   assign OKRDEN      = state_q == FETCH;
   assign OKADDR      = OKRDEN ? cnt_q[ADDR_W-1:0] : '0;
   assign OQWREN      = state_q == STORE;
   assign OQADDR      = OQWREN ? cnt_q : '0;
   assign OQ          = OQWREN ? q_sel[cnt_q[ADDR_W-1:0] * WORD_W +: WORD_W] : '0;
   assign OCORE_START = state_q == START;
   assign OCORE_K     = k_q;
endmodule

// File: tb/tb_ed25519_bpm_io_sequencer.sv
// tb_ed25519_bpm_io_sequencer: checks four parameter sets against a word-level reference model
module tb_ed25519_bpm_io_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int checks = 0, errors = 0, fin = 0;
   typedef struct {
      logic [255:0] k;
      int           mode;
      logic [31:0]  lo;
      logic [31:0]  hi;
      bit           hand;
   } vec_t;
   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   for (genvar g = 0; g < 4; g++) begin : cfg
      localparam int W  = g == 3 ? 64 : 32;
      localparam int L  = g == 1 ? 2 : 1;
      localparam int C  = g == 2 ? 0 : 1;
      localparam int X  = g == 3 ? 1 : 0;
      localparam int NW = 256 / W;
      localparam int AW = $clog2(NW);
      logic          ien = 1'b0, irst = 1'b1, spur = 1'b0;
      logic          oready, odone, okrden, oqwren, ostart, cdone;
      logic [AW-1:0] okaddr;
      logic [AW:0]   oqaddr;
      logic [W-1:0]  ik, oq, ik_r = '0, junk = '0;
      logic [255:0]  ocore_k, kval = '0, kcore = '0;
      int            cyc = 0, tmr = 0;
      vec_t          tv[6];
      ed25519_bpm_io_sequencer #(.WORD_W(W), .READ_LAT(L), .CLAMP(C), .OUT_X(X)) dut (
         .ICLK(clk), .IRST(irst), .IEN(ien), .OREADY(oready), .ODONE(odone),
         .OKADDR(okaddr), .OKRDEN(okrden), .IK(ik), .OQADDR(oqaddr), .OQWREN(oqwren),
         .OQ(oq), .OCORE_START(ostart), .OCORE_K(ocore_k), .ICORE_DONE(cdone),
         .ICORE_QY(kcore + 256'd1), .ICORE_QX(~kcore));
      always @(posedge clk) begin
         cyc   <= cyc + 1;
         junk  <= W'({$urandom, $urandom});
         ik_r  <= okrden ? kval[okaddr * W +: W] : junk;
         tmr   <= irst ? 0 : ostart ? 10 : (tmr > 0 ? tmr - 1 : 0);
         if (ostart) kcore <= ocore_k;
      end
      assign ik    = L == 1 ? (okrden ? kval[okaddr * W +: W] : junk) : ik_r;
      assign cdone = tmr == 1 || spur;
      function automatic logic [255:0] expk(input logic [255:0] k);
         return C != 0 ? (k & ~(256'd7 | (256'd1 << 255))) | (256'd1 << 254) : k;
      endfunction
      task automatic ck(input string n, input logic [255:0] a, input logic [255:0] e);
         chk($sformatf("cfg%0d %s", g, n), a, e);
      endtask
      task automatic run(input vec_t v);
         logic [255:0] ek, eq;
         int st, dn, fw, nwr, t0, rel;
         bit bad_oq, bad_rdy;
         ek = expk(v.k);
         st = -1; dn = -1; fw = -1; nwr = 0;
         bad_oq = 0; bad_rdy = 0;
         kval = v.k;
         @(negedge clk);
         ien = 1'b1;
         t0  = cyc;
         for (int c = 0; c < 300 && dn < 0; c++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (oready) bad_rdy = 1;
            if (!oqwren && oq != '0) bad_oq = 1;
            if (ostart) begin
               st = rel;
               ck("ocore_k", ocore_k, ek);
               if (v.hand) begin
                  ck("ocore_k word0", ocore_k[31:0], v.lo);
                  ck("ocore_k word7", ocore_k[255:224], v.hi);
               end
            end
            if (oqwren) begin
               if (fw < 0) fw = rel;
               eq = (nwr < NW ? ek + 256'd1 : ~ek) >> ((nwr % NW) * W);
               ck($sformatf("oqaddr w%0d", nwr), oqaddr, nwr);
               ck($sformatf("oq w%0d", nwr), oq, eq[W-1:0]);
               nwr++;
               if (v.mode == 2 && nwr == 3) begin
                  irst = 1'b1;
                  @(negedge clk);
                  ck("oready after reset", oready, 1);
                  ck("outputs after reset", {okrden, oqwren, ostart, odone, okaddr, oqaddr, oq}, 0);
                  ck("ocore_k after reset", ocore_k, 0);
                  irst = 1'b0;
                  return;
               end
            end
            if (odone) dn = rel;
            ien  = v.mode == 1 && (rel == 3 || (st > 0 && rel == st + 4));
            spur = v.mode == 1 && rel == 2;
         end
         ien  = 1'b0;
         spur = 1'b0;
         ck("start cycle", st, NW + L);
         ck("first write cycle", fw, st + 11);
         ck("write count", nwr, NW * (X + 1));
         ck("done cycle", dn, fw + nwr);
         ck("oready low while busy", bad_rdy, 0);
         ck("oq zero when idle", bad_oq, 0);
         @(negedge clk);
         ck("oready after done", oready, 1);
      endtask
      initial begin
         logic [255:0] kw;
         for (int i = 0; i < 8; i++) kw[i * 32 +: 32] = 32'(i + 1);
         tv[0] = '{k: kw, mode: 0, lo: C != 0 ? 32'h0 : 32'h1,
                   hi: C != 0 ? 32'h40000008 : 32'h8, hand: 1};
         tv[1] = '{k: '1, mode: 0, lo: C != 0 ? 32'hFFFFFFF8 : 32'hFFFFFFFF,
                   hi: C != 0 ? 32'h7FFFFFFF : 32'hFFFFFFFF, hand: 1};
         tv[2] = '{k: {1'b0, {255{1'b1}}}, mode: 0, lo: 0, hi: 0, hand: 0};
         for (int i = 3; i < 6; i++)
            tv[i] = '{k: {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                      mode: i == 3 ? 1 : i == 4 ? 2 : 0, lo: 0, hi: 0, hand: 0};
         ien = 1'b1;
         repeat (3) @(negedge clk);
         ck("reset oready", oready, 1);
         ck("reset outputs", {okrden, oqwren, ostart, odone, okaddr, oqaddr, oq}, 0);
         ck("reset ocore_k", ocore_k, 0);
         irst = 1'b0;
         ien  = 1'b0;
         @(negedge clk);
         ck("idle holds", {oready, okrden}, 2'b10);
         for (int i = 0; i < 6; i++) run(tv[i]);
         fin++;
      end
   end
   initial begin
      int t;
      t = 0;
      while (fin < 4 && t < 40000) begin
         @(posedge clk);
         t++;
      end
      if (fin < 4) begin
         errors++;
         $display("FAIL global timeout: %0d of 4 configs finished, required 4", fin);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
